serial_frame_ctrl: RTL and testbench
====================================

SERIAL_FRAME_CTRL -- requirements
Module: serial_frame_ctrl

Interface
REQ-001 Parameter NBITS, default 4: data bits per frame and width of q; legal range 2..8.
REQ-002 clk  input  1  sole clock; all state changes on posedge clk.
REQ-003 res  input  1  reset, synchronous, active-high.
REQ-004 si  input  1  serial line; idles high, one bit per clk cycle.
REQ-005 ena  output  1  shift-enable to the serial-to-parallel datapath; high only during data-bit cycles.
REQ-006 q  output  NBITS  last accepted data word; first data bit received lands in q[NBITS-1].
REQ-007 valid  output  1  q holds an unacknowledged word.
REQ-008 ack  input  1  consumer accepts q; effective only while valid=1.
REQ-009 busy  output  1  frame in progress (state other than IDLE).
REQ-010 frame_err  output  1  one-cycle pulse on a bad stop bit (or parity, see Configuration).
REQ-011 overrun  output  1  sticky; a good frame was dropped because valid was held.

Function
REQ-012 Frame format: start bit 0, NBITS data bits MSB first, [parity bit], stop bit 1.
REQ-013 FSM states: IDLE, DATA, PAR (only with PARITY_EN), STOP; encoding is free.
REQ-014 IDLE: si=0 sampled -> DATA, bit counter loaded with NBITS-1; si=1 -> stay IDLE.
REQ-015 DATA: ena=1 (decoded from state, same cycle); si written to shadow[counter]; counter decrements; at counter=0 -> PAR or STOP.
REQ-016 STOP, si=1: frame good; if valid=0 or ack=1 this cycle -> q<=shadow and valid=1 next cycle; else q unchanged, overrun<=1.
REQ-017 STOP, si=0: frame_err=1 for the next cycle only; shadow discarded; q and valid unchanged.
REQ-018 STOP -> IDLE unconditionally; a start bit is detected no earlier than the cycle after STOP.
REQ-019 Latency: valid rises exactly NBITS+2 cycles (NBITS+3 with parity) after the start-bit sample edge.
REQ-020 valid=1 and ack=1 with no completing frame -> valid=0 next cycle; ack with valid=0 ignored.
REQ-021 Simultaneous ack and good-frame completion -> new word loaded, valid stays 1, no overrun.
REQ-022 overrun clears only when ack is seen with valid=1 (or on reset).
REQ-023 busy=1 in DATA, PAR, STOP; 0 in IDLE.
REQ-024 q never changes except on a good-frame load (REQ-016) or reset.

Reset
REQ-025 res=1 at posedge: state IDLE, counter 0, shadow 0, q=0, valid=0, frame_err=0, overrun=0; ena=0, busy=0.
REQ-026 res overrides every other input, including mid-frame; the partial frame is discarded with no frame_err.
REQ-027 After res deasserts, si=0 in the first cycle is a valid start bit.

Configuration
REQ-028 Macro SERIAL_FRAME_PARITY_EN defined: PAR state inserted after DATA; bit sampled there must give even parity over data+parity, else frame treated as bad (frame_err pulse after STOP, no load, regardless of stop bit).
REQ-029 Macro undefined: no PAR state; DATA goes directly to STOP; frame length NBITS+2.

Verification (NBITS=4)
REQ-030 Reset then si=0,1,1,0,0,1 -> ena high 4 cycles, q=4'b1100, valid=1 one cycle after stop sample, frame_err=0.
REQ-031 Frame 1010 with stop bit 0 -> frame_err 1-cycle pulse, valid stays 0, q stays 0000.
REQ-032 Frame 1100 (no ack), then frame 0011 -> q stays 1100, overrun=1; ack -> valid=0, overrun=0 next cycle.
REQ-033 Valid held with 1100, ack asserted in stop cycle of frame 0101 -> q=0101, valid stays 1, overrun=0.
REQ-034 res pulsed after 2 data bits -> all outputs 0, no frame_err; next full frame 1001 received correctly.
REQ-035 With SERIAL_FRAME_PARITY_EN: frame 1011 parity 1 stop 1 -> q=1011 valid; parity 0 -> frame_err, no load.

Source files
------------

// File: rtl/serial_frame_ctrl.sv
// Serial frame receiver: start bit, NBITS data bits MSB first, optional even parity, stop bit.
// Define SERIAL_FRAME_PARITY_EN to insert the parity state between data and stop.
module serial_frame_ctrl #(
  parameter int NBITS = 4
) (
  input  logic             clk,
  input  logic             res,
  input  logic             si,
  output logic             ena,
  output logic [NBITS-1:0] q,
  output logic             valid,
  input  logic             ack,
  output logic             busy,
  output logic             frame_err,
  output logic             overrun
);

  // state   | meaning
  // S_IDLE  | line idle, waiting for a start bit (si=0)
  // S_DATA  | shifting data bits into shadow, MSB first
  // S_PAR   | sampling the even-parity bit (parity build only)
  // S_STOP  | sampling the stop bit, committing or rejecting the frame
  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PAR, S_STOP} state_t;

  localparam int CW = 3;
  localparam logic [CW-1:0] CNT_ONE = 1;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [NBITS-1:0] shadow_q, shadow_d;
  logic [NBITS-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
  logic             ovr_q, ovr_d;
  logic             perr_q, perr_d;

  logic good_stop, bad_stop, load;

  always_ff @(posedge clk) begin
    if (res) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      ferr_q   <= 1'b0;
      ovr_q    <= 1'b0;
      perr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      ferr_q   <= ferr_d;
      ovr_q    <= ovr_d;
      perr_q   <= perr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (!si) state_d = S_DATA;
      S_DATA: begin
        if (cnt_q == '0) begin
`ifdef SERIAL_FRAME_PARITY_EN
          state_d = S_PAR;
`else
          state_d = S_STOP;
`endif
        end
      end
      S_PAR:   state_d = S_STOP;
      S_STOP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // A parity failure makes the frame bad regardless of the stop bit.
  assign good_stop = (state_q == S_STOP) && si && !perr_q;
  assign bad_stop  = (state_q == S_STOP) && !good_stop;
  assign load      = good_stop && (!valid_q || ack);

  always_comb begin
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    data_d   = data_q;
    valid_d  = valid_q;
    ovr_d    = ovr_q;
    perr_d   = perr_q;
    ferr_d   = bad_stop;

    case (state_q)
      S_IDLE: begin
        if (!si) begin
          cnt_d  = CW'(NBITS - 1);
          perr_d = 1'b0;
        end
      end
      S_DATA: begin
        for (int i = 0; i < NBITS; i++) begin
          if (cnt_q == CW'(i)) shadow_d[i] = si;
        end
        if (cnt_q != '0) cnt_d = cnt_q - CNT_ONE;
      end
      S_PAR:   perr_d = ^{shadow_q, si};
      default: ;
    endcase

    if (valid_q && ack) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
    if (load) begin
      valid_d = 1'b1;
      data_d  = shadow_q;
    end
    if (good_stop && valid_q && !ack) ovr_d = 1'b1;
  end

  always_comb begin
    ena  = (state_q == S_DATA);
    busy = (state_q != S_IDLE);
  end

  assign q         = data_q;
  assign valid     = valid_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_serial_frame_ctrl.sv
// Scoreboard bench for serial_frame_ctrl (NBITS=4); parity vectors run when SERIAL_FRAME_PARITY_EN is defined.
module tb_serial_frame_ctrl;

  typedef struct packed {
    bit         is_err;
    logic [3:0] data;
  } exp_t;

  logic       clk;
  logic       res;
  logic       si;
  logic       ena;
  logic [3:0] q;
  logic       valid;
  logic       ack;
  logic       busy;
  logic       frame_err;
  logic       overrun;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];

  serial_frame_ctrl #(.NBITS(4)) dut (
    .clk       (clk),
    .res       (res),
    .si        (si),
    .ena       (ena),
    .q         (q),
    .valid     (valid),
    .ack       (ack),
    .busy      (busy),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Monitor: every frame_err pulse or new word presented on q must match the queue head.
  initial begin : monitor
    logic       valid_prev;
    logic [3:0] q_prev;
    exp_t       e;
    valid_prev = 1'b0;
    q_prev     = '0;
    forever begin
      @(negedge clk);
      if (frame_err === 1'b1) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL sb_err: frame_err pulse seen, nothing expected");
        end else begin
          e = sb.pop_front();
          if (!e.is_err) begin
            n_bad++;
            $display("FAIL sb_err: frame_err pulse seen, required load of %b", e.data);
          end
        end
      end
      if (valid === 1'b1 && (valid_prev !== 1'b1 || q !== q_prev)) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL sb_load: word %b presented, nothing expected", q);
        end else begin
          e = sb.pop_front();
          if (e.is_err || q !== e.data) begin
            n_bad++;
            $display("FAIL sb_load: got q=%b, required %s %b", q,
                     e.is_err ? "frame_err for" : "load of", e.data);
          end
        end
      end
      valid_prev = valid;
      q_prev     = q;
    end
  end

  task automatic expect_load(input logic [3:0] d);
    exp_t e;
    e.is_err = 1'b0;
    e.data   = d;
    sb.push_back(e);
  endtask

  task automatic expect_err(input logic [3:0] d);
    exp_t e;
    e.is_err = 1'b1;
    e.data   = d;
    sb.push_back(e);
  endtask

  // Ends on the negedge after the stop-bit sample edge, where the outcome is visible.
  task automatic send_frame(input logic [3:0] d, input logic stopb, input logic ack_stop,
                            input logic par_flip, output int ena_cnt);
    ena_cnt = 0;
    @(negedge clk); res = 1'b0; si = 1'b0; ack = 1'b0; ena_cnt += int'(ena);
    for (int i = 3; i >= 0; i--) begin
      @(negedge clk); si = d[i]; ena_cnt += int'(ena);
    end
`ifdef SERIAL_FRAME_PARITY_EN
    @(negedge clk); si = (^d) ^ par_flip; ena_cnt += int'(ena);
`endif
    @(negedge clk); si = stopb; ack = ack_stop; ena_cnt += int'(ena);
    @(negedge clk); si = 1'b1; ack = 1'b0;
  endtask

  task automatic ack_pulse();
    @(negedge clk); ack = 1'b1;
    @(negedge clk); ack = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); res = 1'b1; si = 1'b1; ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_q"},         32'(q),         32'h0);
    chk({tag, "_valid"},     32'(valid),     32'h0);
    chk({tag, "_ena"},       32'(ena),       32'h0);
    chk({tag, "_busy"},      32'(busy),      32'h0);
    chk({tag, "_frame_err"}, 32'(frame_err), 32'h0);
    chk({tag, "_overrun"},   32'(overrun),   32'h0);
  endtask

  initial begin : stim
    int ec;
    res = 1'b1;
    si  = 1'b1;
    ack = 1'b0;

    do_reset();
    chk_all_zero("reset");

    // Start bit in the first cycle after reset release.
    expect_load(4'b1100);
    send_frame(4'b1100, 1'b1, 1'b0, 1'b0, ec);
    chk("basic_ena_cycles", 32'(ec),        32'd4);
    chk("basic_valid",      32'(valid),     32'h1);
    chk("basic_q",          32'(q),         32'hC);
    chk("basic_frame_err",  32'(frame_err), 32'h0);
    chk("basic_busy_idle",  32'(busy),      32'h0);
    ack_pulse();
    chk("basic_ack_valid",  32'(valid),     32'h0);
    chk("basic_ack_q_hold", 32'(q),         32'hC);

    do_reset();
    expect_err(4'b1010);
    send_frame(4'b1010, 1'b0, 1'b0, 1'b0, ec);
    chk("badstop_frame_err", 32'(frame_err), 32'h1);
    chk("badstop_valid",     32'(valid),     32'h0);
    chk("badstop_q",         32'(q),         32'h0);
    @(negedge clk);
    chk("badstop_pulse_len", 32'(frame_err), 32'h0);

    // Held word plus a second good frame -> overrun, q untouched.
    expect_load(4'b1100);
    send_frame(4'b1100, 1'b1, 1'b0, 1'b0, ec);
    send_frame(4'b0011, 1'b1, 1'b0, 1'b0, ec);
    chk("ovr_q_hold",  32'(q),       32'hC);
    chk("ovr_valid",   32'(valid),   32'h1);
    chk("ovr_set",     32'(overrun), 32'h1);
    @(negedge clk);
    chk("ovr_sticky",  32'(overrun), 32'h1);
    ack_pulse();
    chk("ovr_ack_valid", 32'(valid),   32'h0);
    chk("ovr_ack_clear", 32'(overrun), 32'h0);

    // Ack coincident with the stop bit of the next frame.
    expect_load(4'b1100);
    send_frame(4'b1100, 1'b1, 1'b0, 1'b0, ec);
    expect_load(4'b0101);
    send_frame(4'b0101, 1'b1, 1'b1, 1'b0, ec);
    chk("ackstop_q",       32'(q),       32'h5);
    chk("ackstop_valid",   32'(valid),   32'h1);
    chk("ackstop_overrun", 32'(overrun), 32'h0);
    ack_pulse();
    chk("ackstop_cleared", 32'(valid),   32'h0);

    // Reset mid-frame after two data bits.
    @(negedge clk); si = 1'b0;
    @(negedge clk); si = 1'b1;
    @(negedge clk); si = 1'b0;
    chk("midres_busy_before", 32'(busy), 32'h1);
    @(negedge clk); res = 1'b1; si = 1'b1;
    @(negedge clk);
    chk_all_zero("midres");
    expect_load(4'b1001);
    send_frame(4'b1001, 1'b1, 1'b0, 1'b0, ec);
    chk("midres_next_q",     32'(q),     32'h9);
    chk("midres_next_valid", 32'(valid), 32'h1);
    ack_pulse();

`ifdef SERIAL_FRAME_PARITY_EN
    expect_load(4'b1011);
    send_frame(4'b1011, 1'b1, 1'b0, 1'b0, ec);
    chk("par_good_q",     32'(q),     32'hB);
    chk("par_good_valid", 32'(valid), 32'h1);
    ack_pulse();
    expect_err(4'b1011);
    send_frame(4'b1011, 1'b1, 1'b0, 1'b1, ec);
    chk("par_bad_frame_err", 32'(frame_err), 32'h1);
    chk("par_bad_valid",     32'(valid),     32'h0);
    chk("par_bad_q_hold",    32'(q),         32'hB);
`endif

    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
